// File: rtl/arb_pkg.sv
// Shared types and constants for the RAM bus arbiter.
// State enum, default widths, wait-counter width, index-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

  localparam int ARB_AW  = 8;
  localparam int ARB_DW  = 8;
  localparam int ARB_WCW = 3;

  // index width for n requesters, never below 1 bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_picker.sv
// rr_picker: combinational one-hot round-robin select.
// Ports: req (requests), last (previous winner) -> gnt, idx, any.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // search starts just after the previous winner
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[IW'(k)]) begin
        any          = 1'b1;
        gnt[IW'(k)]  = 1'b1;
        idx          = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM among NREQ requesters, with
// fixed wait states, ack pulse and optional lock timeout (ARB_TIMEOUT_EN).
// Ports: i_clk, i_rst (async, low); per-requester i_req/i_lock/i_wen/
// i_addr/i_wdata; o_gnt, o_ack, o_rdata; RAM pins o_ram_*/i_ram_rdata;
// o_lock_err forced-release pulse.
module ram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int WAIT_STATES = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_lock,
  input  logic [NREQ-1:0]   i_wen,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_ack,
  output logic [DW-1:0]     o_rdata,
  output logic              o_ram_cen,
  output logic              o_ram_ren,
  output logic              o_ram_wen,
  output logic [AW-1:0]     o_ram_addr,
  output logic [DW-1:0]     o_ram_wdata,
  input  logic [DW-1:0]     i_ram_rdata,
  output logic              o_lock_err
);

  localparam int IW = idx_w(NREQ);

  arb_state_e state, state_nx;

  logic [NREQ-1:0]    gnt, gnt_nx;
  logic [IW-1:0]      gidx, gidx_nx;
  logic [IW-1:0]      last, last_nx;
  logic [ARB_WCW-1:0] wcnt, wcnt_nx;
  logic [DW-1:0]      rdata, rdata_nx;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            acc;
  logic            keep;
  logic            force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [LCW-1:0] lcnt, lcnt_nx;
  logic           lock_err, lock_err_nx;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_LOCK > 0);
`endif

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req  (i_req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    gidx_nx  = gidx;
    last_nx  = last;
    wcnt_nx  = wcnt;
    rdata_nx = rdata;
    keep     = i_lock[gidx] & i_req[gidx];
`ifdef ARB_TIMEOUT_EN
    lcnt_nx     = lcnt;
    lock_err_nx = 1'b0;
    force_rel   = (lcnt == LCW'(MAX_LOCK - 1));
`else
    force_rel   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = ACCESS;
          gnt_nx   = pick_gnt;
          gidx_nx  = pick_idx;
          wcnt_nx  = '0;
`ifdef ARB_TIMEOUT_EN
          lcnt_nx  = '0;
`endif
        end
      end
      ACCESS: begin
        // requester withdrew: drop the access, no ack
        if (!i_req[gidx]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = gidx;
        end else if (wcnt == ARB_WCW'(WAIT_STATES)) begin
          if (!i_wen[gidx]) rdata_nx = i_ram_rdata;
          state_nx = ACK;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      ACK: begin
        if (keep && !force_rel) begin
          state_nx = ACCESS;
          wcnt_nx  = '0;
`ifdef ARB_TIMEOUT_EN
          lcnt_nx  = lcnt + 1'b1;
`endif
        end else begin
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = gidx;
`ifdef ARB_TIMEOUT_EN
          lock_err_nx = keep & force_rel;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      last  <= IW'(NREQ - 1);
      wcnt  <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      gidx  <= gidx_nx;
      last  <= last_nx;
      wcnt  <= wcnt_nx;
      rdata <= rdata_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lcnt     <= '0;
      lock_err <= 1'b0;
    end else begin
      lcnt     <= lcnt_nx;
      lock_err <= lock_err_nx;
    end
  end

  assign o_lock_err = lock_err;
`else
  assign o_lock_err = 1'b0;
`endif

  assign acc         = (state == ACCESS);
  assign o_gnt       = gnt;
  assign o_ack       = (state == ACK) ? gnt : '0;
  assign o_rdata     = rdata;
  assign o_ram_cen   = acc;
  assign o_ram_wen   = acc & i_wen[gidx];
  assign o_ram_ren   = acc & ~i_wen[gidx];
  assign o_ram_addr  = acc ? i_addr[gidx*AW +: AW] : '0;
  assign o_ram_wdata = acc ? i_wdata[gidx*DW +: DW] : '0;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Testbench for ram_bus_arbiter: directed scenarios plus random traffic
// against a transaction-timeline reference model.
module tb_ram_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int WS   = 1;
  localparam int ML   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req, lock, wen;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata;
  logic               cen, ren, ram_wen;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_wdata, ram_rdata;
  logic               lock_err;

  logic [DW-1:0] ram  [256];
  logic [DW-1:0] refm [256];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr];

  ram_bus_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW),
    .WAIT_STATES(WS), .MAX_LOCK(ML)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req(req), .i_lock(lock), .i_wen(wen),
    .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata),
    .o_ram_cen(cen), .o_ram_ren(ren), .o_ram_wen(ram_wen),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata),
    .o_lock_err(lock_err)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, act, exp, cyc);
    end
  endtask

  // RAM write lands mid-cycle, outputs sampled 1ns after the edge
  task automatic tick();
    @(negedge clk);
    if (cen && ram_wen) ram[ram_addr] = ram_wdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int k, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[k]            = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    req[k]            = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [4];
    int nack, n0, w, t0, dt, k;
    bit seen, active, tw, free;
    logic [AW-1:0] ta;
    logic [DW-1:0] td, trd, exp_rd;
    int last;
    logic [NREQ-1:0] eg, ea;
    bit ec;

    rst = 1'b0; req = '0; lock = '0; wen = '0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[8'h10] = 8'hA5;

    // reset state
    #12;
    check("rst_gnt",   32'(gnt), 0);
    check("rst_ack",   32'(ack), 0);
    check("rst_cen",   32'(cen), 0);
    check("rst_ren",   32'(ren), 0);
    check("rst_wen",   32'(ram_wen), 0);
    check("rst_addr",  32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_lerr",  32'(lock_err), 0);
    @(posedge clk); #1; rst = 1'b1;

    // single read, addr 0x10 holding 0xA5
    set_req(0, 1'b0, 8'h10, 8'h00);
    tick();
    check("rd_gnt1", 32'(gnt), 1);
    check("rd_cen1", 32'(cen), 1);
    check("rd_ren1", 32'(ren), 1);
    check("rd_addr1", 32'(ram_addr), 'h10);
    tick();
    check("rd_cen2", 32'(cen), 1);
    check("rd_ack2", 32'(ack), 0);
    tick();
    check("rd_ack3", 32'(ack), 1);
    check("rd_data3", 32'(rdata), 'hA5);
    check("rd_cen3", 32'(cen), 0);
    req[0] = 1'b0;
    tick();
    check("rd_idle4", 32'(gnt), 0);

    // async reset mid-access, then priority back to requester 0
    set_req(0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b0, 8'h30, 8'h00);
    tick();
    check("ar_gnt", 32'(gnt), 2);
    #2 rst = 1'b0;
    #1;
    check("ar_gnt0", 32'(gnt), 0);
    check("ar_cen0", 32'(cen), 0);
    check("ar_rd0",  32'(rdata), 0);
    @(posedge clk); #1; rst = 1'b1;
    tick();
    check("ar_first", 32'(gnt), 1);

    // fairness with both requests held
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    nack = 0;
    for (int c = 1; c <= 16; c++) begin
      if (ack != '0) begin
        if (nack < 4) check("fair_ack", 32'(ack), 32'(seq[nack]));
        nack++;
      end
      if (c < 16) tick();
    end
    check("fair_nack", nack, 4);
    req = '0;
    tick();
    check("fair_idle", 32'(gnt), 0);

    // locked burst of three accesses, requester 1 waits
    set_req(0, 1'b0, 8'h10, 8'h00);
    lock[0] = 1'b1;
    set_req(1, 1'b0, 8'h11, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("lk_gnt", 32'(gnt), 1);
      check("lk_ack", 32'(ack), (c % 3 == 0) ? 1 : 0);
      check("lk_cen", 32'(cen), (c % 3 != 0) ? 1 : 0);
      if (c == 9) begin
        req[0] = 1'b0;
        lock[0] = 1'b0;
      end
    end
    tick();
    check("lk_gap", 32'(gnt), 0);
    tick();
    check("lk_next", 32'(gnt), 2);
    tick();
    tick();
    check("lk_ack1", 32'(ack), 2);
    check("lk_rd1", 32'(rdata), 32'(ram[8'h11]));
    req[1] = 1'b0;
    tick();

    // abort of a write in its first access cycle
    set_req(0, 1'b1, 8'h40, 8'h3C);
    set_req(1, 1'b0, 8'h41, 8'h00);
    tick();
    check("ab_gnt", 32'(gnt), 1);
    check("ab_wen", 32'(ram_wen), 1);
    check("ab_wd",  32'(ram_wdata), 'h3C);
    req[0] = 1'b0;
    tick();
    check("ab_ack", 32'(ack), 0);
    check("ab_cen", 32'(cen), 0);
    check("ab_idle", 32'(gnt), 0);
    tick();
    check("ab_next", 32'(gnt), 2);
    check("ab_addr", 32'(ram_addr), 'h41);
    tick();
    tick();
    check("ab_ack1", 32'(ack), 2);
    req[1] = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // lock held forever: forced release after ML accesses
    set_req(0, 1'b0, 8'h10, 8'h00);
    lock[0] = 1'b1;
    set_req(1, 1'b0, 8'h11, 8'h00);
    n0 = 0;
    seen = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (ack[0]) n0++;
      if (lock_err) begin
        seen = 1'b1;
        check("to_acks", n0, ML);
        check("to_gnt0", 32'(gnt), 0);
      end
    end
    check("to_seen", 32'(seen), 1);
    check("to_gnt1", 32'(gnt), 2);
    req = '0;
    lock = '0;
    tick();
    tick();
`endif

    // random traffic against a timeline model
    rst = 1'b0;
    #2;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 256; i++) refm[i] = ram[i];
    last = NREQ - 1;
    active = 1'b0;
    t0 = 0; w = 0; tw = 1'b0; ta = '0; td = '0; trd = '0;
    exp_rd = '0;
    req = '0;
    for (int n = 0; n < 300; n++) begin
      tick();
      dt = cyc - t0;
      eg = '0;
      ea = '0;
      ec = 1'b0;
      if (active && dt >= 1 && dt <= WS + 2) eg = NREQ'(1 << w);
      if (active && dt == WS + 2) ea = NREQ'(1 << w);
      if (active && dt >= 1 && dt <= WS + 1) ec = 1'b1;
      if (ea != '0 && !tw) exp_rd = trd;
      check("rn_gnt", 32'(gnt), 32'(eg));
      check("rn_ack", 32'(ack), 32'(ea));
      check("rn_cen", 32'(cen), 32'(ec));
      check("rn_wen", 32'(ram_wen), 32'(ec & tw));
      check("rn_ren", 32'(ren), 32'(ec & ~tw));
      check("rn_addr", 32'(ram_addr), ec ? 32'(ta) : 0);
      check("rn_wd", 32'(ram_wdata), ec ? 32'(td) : 0);
      check("rn_rd", 32'(rdata), 32'(exp_rd));
      check("rn_lerr", 32'(lock_err), 0);
      // requester behaviour
      for (int j = 0; j < NREQ; j++) begin
        if (ack[j]) req[j] = 1'b0;
        else if (!req[j] && $urandom_range(0, 2) == 0)
          set_req(j, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), DW'($urandom));
      end
      // model: a new access may start once the previous one has fully ended
      free = !active || (dt >= WS + 3);
      if (free) begin
        active = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
          k = (last + i) % NREQ;
          if (!active && req[k]) begin
            active = 1'b1;
            w  = k;
            t0 = cyc;
            tw = wen[k];
            ta = addr[k*AW +: AW];
            td = wdata[k*DW +: DW];
            if (tw) refm[ta] = td;
            else    trd = refm[ta];
            last = k;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
